// File: rtl/fp_alu_pkg.sv
// Shared FP ALU definitions: field widths, exponent bias, normaliser state
// encoding and the single-precision field packer.
package fp_alu_pkg;

   localparam int EXP_W  = 8;
   localparam int MANT_W = 24;
   localparam int BIAS   = 127;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_DONE = 2'd2
   } norm_state_e;

   function automatic logic [EXP_W+MANT_W-1:0] pack_fp(
      input logic              sign,
      input logic [EXP_W-1:0]  exp,
      input logic [MANT_W-2:0] frac
   );
      return {sign, exp, frac};
   endfunction

endpackage

// File: rtl/fp_sub_normalize.sv
// Post-subtract normaliser: one left shift per cycle until the hidden bit is set.
// Latency k+2 cycles for k shifts (2..25); start is ignored unless idle, never queued.
module fp_sub_normalize
   import fp_alu_pkg::*;
#(
   parameter int MANT_W = fp_alu_pkg::MANT_W,
   parameter int EXP_W  = fp_alu_pkg::EXP_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [MANT_W-1:0]         mant_in,
   input  logic [EXP_W-1:0]          exp_in,
   input  logic                      sign_in,
   output logic                      busy,
   output logic                      done,
   output logic [EXP_W+MANT_W-1:0]   result,
   output logic                      zero,
   output logic                      underflow
);

   norm_state_e               state_q, state_d;
   logic [MANT_W-1:0]         mant_q, mant_d;
   logic [EXP_W-1:0]          exp_q, exp_d;
   logic                      sign_q, sign_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic [EXP_W+MANT_W-1:0]   result_q, result_d;
   logic                      zero_q, zero_d;
   logic                      uflow_q, uflow_d;

   always_comb begin
      state_d  = state_q;
      mant_d   = mant_q;
      exp_d    = exp_q;
      sign_d   = sign_q;
      zero_d   = zero_q;
      uflow_d  = uflow_q;
      result_d = result_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mant_d  = mant_in;
               exp_d   = exp_in;
               sign_d  = sign_in;
               zero_d  = 1'b0;
               uflow_d = 1'b0;
               state_d = ST_NORM;
            end
         end
         ST_NORM: begin
            if (mant_q == '0) begin
               exp_d   = '0;
               sign_d  = 1'b0;
               zero_d  = 1'b1;
               state_d = ST_DONE;
            end else if (mant_q[MANT_W-1]) begin
               state_d = ST_DONE;
            end else if (exp_q <= EXP_W'(1)) begin
               // Denormal: exponent field 0 carries the same scale as 1.
               exp_d   = '0;
               uflow_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               mant_d = {mant_q[MANT_W-2:0], 1'b0};
               exp_d  = exp_q - EXP_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Result is captured on the edge entering DONE so it lines up with done.
      if (state_d == ST_DONE) begin
         result_d = pack_fp(sign_d, exp_d, mant_d[MANT_W-2:0]);
      end

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         mant_q   <= '0;
         exp_q    <= '0;
         sign_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         uflow_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mant_q   <= mant_d;
         exp_q    <= exp_d;
         sign_q   <= sign_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         uflow_q  <= uflow_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign underflow = uflow_q;

endmodule

// File: tb/tb_fp_sub_normalize.sv
// Directed self-checking bench for fp_sub_normalize: latency, packed result,
// flags, abort by reset and ignored starts.
module tb_fp_sub_normalize;

   logic        clk;
   logic        reset;
   logic        start;
   logic [23:0] mant_in;
   logic [7:0]  exp_in;
   logic        sign_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;
   logic        underflow;

   int total;
   int bad;

   fp_sub_normalize dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mant_in   (mant_in),
      .exp_in    (exp_in),
      .sign_in   (sign_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .zero      (zero),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one start and returns the cycle index in which done is seen
   // (accept edge = edge 0), or -1 if done never arrives. Leaves the bench
   // sitting at the falling edge of the done cycle.
   task automatic run_op(input logic [23:0] m, input logic [7:0] e, input logic s,
                         output int lat);
      @(negedge clk);
      start   = 1'b1;
      mant_in = m;
      exp_in  = e;
      sign_in = s;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      for (int cyc = 1; cyc < 40; cyc++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      mant_in = '0;
      exp_in = '0;
      sign_in = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, done, zero, underflow} !== 4'b0000 || result !== 32'h0) begin
         bad++;
         $display("FAIL reset_state: busy=%b done=%b zero=%b uf=%b result=%h, want all 0",
                  busy, done, zero, underflow, result);
      end
   endtask

   task automatic test_case(input string name, input logic [23:0] m, input logic [7:0] e,
                            input logic s, input int exp_lat, input logic [31:0] exp_res,
                            input logic exp_zero, input logic exp_uf);
      int lat;
      run_op(m, e, s, lat);
      total++;
      if (lat !== exp_lat) begin
         bad++;
         $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
      end
      total++;
      if (result !== exp_res || zero !== exp_zero || underflow !== exp_uf || busy !== 1'b1) begin
         bad++;
         $display("FAIL %s_result: result=%h zero=%b uf=%b busy=%b, want %h %b %b 1",
                  name, result, zero, underflow, busy, exp_res, exp_zero, exp_uf);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res || zero !== exp_zero ||
          underflow !== exp_uf) begin
         bad++;
         $display("FAIL %s_hold: done=%b busy=%b result=%h zero=%b uf=%b, want 0 0 %h %b %b",
                  name, done, busy, result, zero, underflow, exp_res, exp_zero, exp_uf);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int pulses;
      run_op(24'h800000, 8'h80, 1'b0, lat);
      total++;
      if (lat !== 2 || result !== 32'h4000_0000) begin
         bad++;
         $display("FAIL b2b_first: lat=%0d result=%h, want 2 40000000", lat, result);
      end
      // start during the done cycle must be dropped
      start   = 1'b1;
      mant_in = 24'h400000;
      exp_in  = 8'h7F;
      sign_in = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) pulses++;
      end
      total++;
      if (pulses !== 0 || result !== 32'h4000_0000) begin
         bad++;
         $display("FAIL b2b_ignored: active_cycles=%0d result=%h, want 0 40000000", pulses, result);
      end
      run_op(24'h400000, 8'h7F, 1'b1, lat);
      total++;
      if (lat !== 3 || result !== 32'hBF00_0000) begin
         bad++;
         $display("FAIL b2b_second: lat=%0d result=%h, want 3 bf000000", lat, result);
      end
      @(negedge clk);
   endtask

   task automatic test_abort();
      int lat;
      int pulses;
      @(negedge clk);
      start   = 1'b1;
      mant_in = 24'h000001;
      exp_in  = 8'h80;
      sign_in = 1'b0;
      @(posedge clk);                      // edge 0
      #1 start = 1'b0;
      repeat (2) @(posedge clk);           // edges 1, 2
      #1 start = 1'b1;                     // sampled at edge 3, must be ignored
      mant_in = 24'h800000;
      exp_in  = 8'h10;
      @(posedge clk);                      // edge 3
      #1 start = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL abort_busy_ignore: busy=%b done=%b, want 1 0", busy, done);
      end
      @(posedge clk);                      // edge 4
      #1 reset = 1'b1;
      @(posedge clk);                      // edge 5
      #1 reset = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
         bad++;
         $display("FAIL abort_reset: busy=%b done=%b result=%h, want 0 0 00000000",
                  busy, done, result);
      end
      pulses = 0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) pulses++;
      end
      total++;
      if (pulses !== 0) begin
         bad++;
         $display("FAIL abort_no_done: active_cycles=%0d want 0", pulses);
      end
      run_op(24'h400000, 8'h7F, 1'b1, lat);
      total++;
      if (lat !== 3 || result !== 32'hBF00_0000 || zero !== 1'b0 || underflow !== 1'b0) begin
         bad++;
         $display("FAIL abort_restart: lat=%0d result=%h zero=%b uf=%b, want 3 bf000000 0 0",
                  lat, result, zero, underflow);
      end
      @(negedge clk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_case("normalised", 24'h800000, 8'h80, 1'b0, 2,  32'h4000_0000, 1'b0, 1'b0);
      test_case("one_shift",  24'h400000, 8'h7F, 1'b1, 3,  32'hBF00_0000, 1'b0, 1'b0);
      test_case("max_shift",  24'h000001, 8'h80, 1'b0, 25, 32'h3480_0000, 1'b0, 1'b0);
      test_case("zero",       24'h000000, 8'h90, 1'b1, 2,  32'h0000_0000, 1'b1, 1'b0);
      // 4 shifts (exp 5 -> 1), then one cycle for the denormal decision
      test_case("underflow",  24'h001000, 8'h05, 1'b0, 6,  32'h0001_0000, 1'b0, 1'b1);
      test_case("exp_one",    24'h400000, 8'h01, 1'b1, 2,  32'h8040_0000, 1'b0, 1'b1);
      test_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
